// File: rtl/xadc_pkg.sv
// ----------------------------------------------------------------------------
// xadc_pkg
// Shared definitions for the XADC DRP scheduler:
//   - DRP addresses of the six status registers read by the automatic scan,
//     plus the scan list that maps scan index 0..5 to those addresses
//   - FSM state enum and transaction-owner enum
// ----------------------------------------------------------------------------
package xadc_pkg;

    localparam int SCAN_LEN = 6;

    localparam logic [6:0] XADC_ADDR_TEMP    = 7'h00;
    localparam logic [6:0] XADC_ADDR_VCCINT  = 7'h01;
    localparam logic [6:0] XADC_ADDR_VCCAUX  = 7'h02;
    localparam logic [6:0] XADC_ADDR_VCCBRAM = 7'h06;
    localparam logic [6:0] XADC_ADDR_AUX2    = 7'h12;
    localparam logic [6:0] XADC_ADDR_AUX3    = 7'h13;

    // Scan index i reads XADC_SCAN_LIST[i] into the i-th measured_* result.
    localparam logic [6:0] XADC_SCAN_LIST [SCAN_LEN] = '{
        XADC_ADDR_TEMP, XADC_ADDR_VCCINT, XADC_ADDR_VCCAUX,
        XADC_ADDR_VCCBRAM, XADC_ADDR_AUX2, XADC_ADDR_AUX3
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RDY,
        ST_FINISH
    } drp_state_e;

    typedef enum logic {
        OWNER_HOST,
        OWNER_SCAN
    } owner_e;

endpackage

// File: rtl/drp_timeout_counter.sv
// ----------------------------------------------------------------------------
// drp_timeout_counter
// Counts DCLK cycles of an outstanding DRP transaction and flags expiry.
//   clk      in  DRP clock, rising edge
//   rst      in  asynchronous active-high reset
//   run      in  high while a transaction is outstanding (ISSUE or WAIT_RDY);
//                low clears the count, so it reads 0 during the ISSUE cycle
//   expired  out high when the count has reached TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module drp_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/xadc_drp_scheduler.sv
// ----------------------------------------------------------------------------
// xadc_drp_scheduler
// Shares the XADC DRP between an automatic scan engine (six status reads per
// end-of-sequence) and a host read/write port. Host wins arbitration in IDLE;
// a scan is interruptible between reads, never within one.
//   DCLK, RESET              clock / asynchronous active-high reset
//   eos                      end-of-sequence pulse, requests a scan
//   host_req/we/addr/di      host transaction (req held until host_ack)
//   host_ack, host_do        completion pulse and read data
//   den/dwe/daddr/di         DRP request outputs
//   do_in, drdy              DRP response inputs
//   measured_*               last scanned raw register values
//   scan_done                pulse after the sixth scan read finishes
//   timeout_err              sticky flag for any aborted transaction
// ----------------------------------------------------------------------------
module xadc_drp_scheduler
    import xadc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 7
) (
    input  logic              DCLK,
    input  logic              RESET,
    input  logic              eos,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_di,
    output logic              host_ack,
    output logic [15:0]       host_do,
    output logic              den,
    output logic              dwe,
    output logic [ADDR_W-1:0] daddr,
    output logic [15:0]       di,
    input  logic [15:0]       do_in,
    input  logic              drdy,
    output logic [15:0]       measured_temp,
    output logic [15:0]       measured_vccint,
    output logic [15:0]       measured_vccaux,
    output logic [15:0]       measured_vccbram,
    output logic [15:0]       measured_aux2,
    output logic [15:0]       measured_aux3,
    output logic              scan_done,
    output logic              timeout_err
);

    localparam logic [2:0] SCAN_LAST = 3'(SCAN_LEN - 1);

    drp_state_e        state, state_n;
    owner_e            owner;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [15:0]       req_di;
    logic [2:0]        scan_idx;
    logic              scan_pending;
    logic              restart;
    logic [15:0]       meas [SCAN_LEN];

    logic load_host, load_scan, capture, expire_evt;
    logic expired, in_scan, scan_step, scan_last;

    drp_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (DCLK),
        .rst     (RESET),
        .run     ((state == ST_ISSUE) || (state == ST_WAIT_RDY)),
        .expired (expired)
    );

    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_n;
    end

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        load_host  = 1'b0;
        load_scan  = 1'b0;
        capture    = 1'b0;
        expire_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (host_req) begin
                    load_host = 1'b1;
                    state_n   = ST_ISSUE;
                end else if (scan_pending) begin
                    load_scan = 1'b1;
                    state_n   = ST_ISSUE;
                end
            end
            ST_ISSUE: state_n = ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                // drdy wins if it lands on the last allowed cycle.
                if (drdy) begin
                    capture = 1'b1;
                    state_n = ST_FINISH;
                end else if (expired) begin
                    expire_evt = 1'b1;
                    state_n    = ST_FINISH;
                end
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // A scan is "in progress" from its first issue until the index wraps,
    // including host interruptions between reads.
    assign in_scan   = (scan_idx != 3'd0) || ((state != ST_IDLE) && (owner == OWNER_SCAN));
    assign scan_step = (state == ST_FINISH) && (owner == OWNER_SCAN);
    assign scan_last = (scan_idx == SCAN_LAST);

    // NOTE: the result registers are reset like any other state because they
    // drive outputs that must read 0 out of reset.
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            owner        <= OWNER_HOST;
            req_addr     <= '0;
            req_we       <= 1'b0;
            req_di       <= '0;
            host_do      <= '0;
            scan_idx     <= '0;
            scan_pending <= 1'b0;
            restart      <= 1'b0;
            timeout_err  <= 1'b0;
            for (int i = 0; i < SCAN_LEN; i++) meas[i] <= '0;
        end else begin
            if (load_host) begin
                owner    <= OWNER_HOST;
                req_addr <= host_addr;
                req_we   <= host_we;
                req_di   <= host_di;
            end else if (load_scan) begin
                owner    <= OWNER_SCAN;
                req_addr <= ADDR_W'(XADC_SCAN_LIST[scan_idx]);
                req_we   <= 1'b0;
                req_di   <= '0;
            end

            if (capture) begin
                if (owner == OWNER_HOST) host_do        <= do_in;
                else                     meas[scan_idx] <= do_in;
            end

            if (expire_evt) timeout_err <= 1'b1;

            if (scan_step && scan_last) begin
                // Another scan follows if eos arrived during this one or
                // coincides with this final FINISH.
                scan_idx     <= '0;
                scan_pending <= restart | eos;
                restart      <= 1'b0;
            end else begin
                if (scan_step) scan_idx <= scan_idx + 3'd1;
                if (eos) begin
                    scan_pending <= 1'b1;
                    if (in_scan) restart <= 1'b1;
                end
            end
        end
    end

    assign den       = (state == ST_ISSUE);
    assign dwe       = den & req_we;
    assign daddr     = den ? req_addr : '0;
    assign di        = den ? req_di : '0;
    assign host_ack  = (state == ST_FINISH) && (owner == OWNER_HOST);
    assign scan_done = scan_step && scan_last;

    assign measured_temp    = meas[0];
    assign measured_vccint  = meas[1];
    assign measured_vccaux  = meas[2];
    assign measured_vccbram = meas[3];
    assign measured_aux2    = meas[4];
    assign measured_aux3    = meas[5];

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// ----------------------------------------------------------------------------
// tb_xadc_drp_scheduler
// Self-checking bench: a DRP slave model with programmable latency answers
// the DUT; expected values come from a register-file model and the scan
// address list kept here, with directed and randomized host traffic.
// ----------------------------------------------------------------------------
module tb_xadc_drp_scheduler;

    logic        DCLK = 1'b0;
    logic        RESET;
    logic        eos, host_req, host_we;
    logic [6:0]  host_addr;
    logic [15:0] host_di;
    logic        host_ack;
    logic [15:0] host_do;
    logic        den, dwe;
    logic [6:0]  daddr;
    logic [15:0] di, do_in;
    logic        drdy;
    logic [15:0] measured_temp, measured_vccint, measured_vccaux;
    logic [15:0] measured_vccbram, measured_aux2, measured_aux3;
    logic        scan_done, timeout_err;

    xadc_drp_scheduler #(.TIMEOUT_CYCLES(64), .ADDR_W(7)) dut (
        .DCLK(DCLK), .RESET(RESET), .eos(eos),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_di(host_di), .host_ack(host_ack), .host_do(host_do),
        .den(den), .dwe(dwe), .daddr(daddr), .di(di),
        .do_in(do_in), .drdy(drdy),
        .measured_temp(measured_temp), .measured_vccint(measured_vccint),
        .measured_vccaux(measured_vccaux), .measured_vccbram(measured_vccbram),
        .measured_aux2(measured_aux2), .measured_aux3(measured_aux3),
        .scan_done(scan_done), .timeout_err(timeout_err)
    );

    always #5 DCLK = ~DCLK;

    int cyc = 0;
    always @(posedge DCLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0]  scan_list [6] = '{7'h00, 7'h01, 7'h02, 7'h06, 7'h12, 7'h13};
    logic [15:0] model_regs [128];
    logic [15:0] exp_meas [6];

    // ---------------- DRP slave ----------------
    logic [15:0] slave_regs [128];
    int          lat = 3;
    logic [7:0]  withhold = 8'hFF;
    int          cnt = 0;
    logic [15:0] resp = '0;
    logic [6:0]  log_addr [$];
    logic        log_we [$];
    logic [15:0] log_di [$];
    int          log_cyc [$];

    initial begin
        drdy  = 1'b0;
        do_in = '0;
        forever begin
            @(negedge DCLK);
            drdy = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    drdy  = 1'b1;
                    do_in = resp;
                end
            end
            if (den) begin
                log_addr.push_back(daddr);
                log_we.push_back(dwe);
                log_di.push_back(di);
                log_cyc.push_back(cyc);
                if (dwe) slave_regs[daddr] = di;
                resp = slave_regs[daddr];
                if ({1'b0, daddr} != withhold) cnt = lat;
            end
        end
    end

    // ---------------- monitors ----------------
    int done_cnt = 0;
    int den_cnt  = 0;
    int to_cyc   = -1;

    initial begin
        forever begin
            @(negedge DCLK);
            if (scan_done) done_cnt++;
            if (den) den_cnt++;
            if (timeout_err && to_cyc < 0) to_cyc = cyc;
            if (dwe) check("dwe_only_with_den", 32'(den), 32'd1);
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [15:0] get_meas(input int i);
        case (i)
            0: return measured_temp;
            1: return measured_vccint;
            2: return measured_vccaux;
            3: return measured_vccbram;
            4: return measured_aux2;
            default: return measured_aux3;
        endcase
    endfunction

    task automatic step();
        @(negedge DCLK);
        #1;
    endtask

    task automatic pulse_eos();
        step(); eos = 1'b1;
        step(); eos = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int i = 0;
        while (log_addr.size() < n && i < budget) begin step(); i++; end
        if (log_addr.size() < n) check("wait_den_timeout", 32'(log_addr.size()), 32'(n));
    endtask

    task automatic wait_done(input int n, input int budget);
        int i = 0;
        while (done_cnt < n && i < budget) begin step(); i++; end
        if (done_cnt < n) check("wait_scan_done_timeout", 32'(done_cnt), 32'(n));
    endtask

    task automatic host_txn(input logic we, input logic [6:0] a, input logic [15:0] d,
                            output logic [15:0] rd, output int ack_cyc);
        rd      = '0;
        ack_cyc = -1;
        step();
        host_req = 1'b1; host_we = we; host_addr = a; host_di = d;
        for (int i = 0; i < 300; i++) begin
            step();
            if (host_ack) begin
                rd      = host_do;
                ack_cyc = cyc;
                break;
            end
        end
        host_req = 1'b0;
        if (ack_cyc < 0) check("host_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_meas(input string tag);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_meas%0d", tag, i), 32'(get_meas(i)), 32'(exp_meas[i]));
    endtask

    task automatic check_scan_order(input string tag, input int base, input int nscans);
        check({tag, "_txn_count"}, 32'(log_addr.size() >= base + 6 * nscans), 32'd1);
        for (int i = 0; i < 6 * nscans; i++)
            if (base + i < log_addr.size())
                check($sformatf("%s_addr%0d", tag, i), 32'(log_addr[base + i]), 32'(scan_list[i % 6]));
    endtask

    // ---------------- directed sequence ----------------
    logic [15:0] rd;
    int          ack, base, sd0, t0, den0;
    logic [6:0]  ra;
    logic        rw;
    logic [15:0] rdat;

    initial begin
        for (int a = 0; a < 128; a++) begin
            slave_regs[a] = 16'h9C40 + 16'(a);
            model_regs[a] = 16'h9C40 + 16'(a);
        end
        for (int i = 0; i < 6; i++) exp_meas[i] = '0;
        RESET = 1'b1; eos = 1'b0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_di = '0;
        #1;
        check("rst_den", 32'(den), 0);
        check("rst_host_ack", 32'(host_ack), 0);
        check("rst_scan_done", 32'(scan_done), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check_meas("rst");
        repeat (3) step();
        RESET = 1'b0;
        repeat (5) step();
        check("idle_no_den", 32'(den_cnt), 0);

        // Basic scan
        base = log_addr.size(); sd0 = done_cnt;
        pulse_eos();
        wait_done(sd0 + 1, 200);
        for (int i = 0; i < 6; i++) exp_meas[i] = model_regs[scan_list[i]];
        check_scan_order("basic", base, 1);
        for (int i = 1; i < 6; i++)
            if (base + i < log_cyc.size())
                check($sformatf("basic_spacing%0d", i), 32'(log_cyc[base + i] - log_cyc[base + i - 1]), 32'(lat + 3));
        check_meas("basic");
        check("basic_aux3", 32'(measured_aux3), 32'h9C53);
        step();
        check("basic_done_once", 32'(done_cnt), 32'(sd0 + 1));
        check("basic_timeout_err", 32'(timeout_err), 0);

        // Host priority during scan read 2
        base = log_addr.size(); sd0 = done_cnt;
        pulse_eos();
        wait_log(base + 3, 100);
        host_txn(1'b0, 7'h40, 16'h0, rd, ack);
        wait_done(sd0 + 1, 200);
        check("prio_txn_count", 32'(log_addr.size()), 32'(base + 7));
        if (log_addr.size() >= base + 7) begin
            check("prio_host_addr", 32'(log_addr[base + 3]), 32'h40);
            check("prio_host_we", 32'(log_we[base + 3]), 0);
            check("prio_host_issue", 32'(log_cyc[base + 3] - log_cyc[base + 2]), 32'(lat + 3));
            check("prio_ack_cycle", 32'(ack - log_cyc[base + 3]), 32'(lat + 1));
            check("prio_resume_addr", 32'(log_addr[base + 4]), 32'h06);
            check("prio_resume_issue", 32'(log_cyc[base + 4] - log_cyc[base + 3]), 32'(lat + 3));
        end
        check("prio_host_do", 32'(rd), 32'(model_regs[7'h40]));
        check_meas("prio");

        // Host write
        base = log_addr.size();
        host_txn(1'b1, 7'h41, 16'h2000, rd, ack);
        model_regs[7'h41] = 16'h2000;
        repeat (10) step();
        check("wr_txn_count", 32'(log_addr.size()), 32'(base + 1));
        if (log_addr.size() > base) begin
            check("wr_dwe", 32'(log_we[base]), 1);
            check("wr_addr", 32'(log_addr[base]), 32'h41);
            check("wr_di", 32'(log_di[base]), 32'h2000);
            check("wr_ack_cycle", 32'(ack - log_cyc[base]), 32'(lat + 1));
        end
        check_meas("wr");

        // Randomized host traffic interleaved with scans
        for (int it = 0; it < 8; it++) begin
            lat  = $urandom_range(1, 8);
            ra   = 7'($urandom_range(0, 127));
            rw   = 1'($urandom_range(0, 1));
            rdat = 16'($urandom);
            base = log_addr.size();
            host_txn(rw, ra, rdat, rd, ack);
            check("rnd_txn_seen", 32'(log_addr.size() > base), 1);
            if (log_addr.size() > base) begin
                check("rnd_addr", 32'(log_addr[base]), 32'(ra));
                check("rnd_we", 32'(log_we[base]), 32'(rw));
                if (rw) check("rnd_di", 32'(log_di[base]), 32'(rdat));
            end
            if (rw) model_regs[ra] = rdat;
            else    check("rnd_host_do", 32'(rd), 32'(model_regs[ra]));
            if (it % 2 == 1) begin
                base = log_addr.size(); sd0 = done_cnt;
                pulse_eos();
                wait_done(sd0 + 1, 300);
                for (int i = 0; i < 6; i++) exp_meas[i] = model_regs[scan_list[i]];
                check_scan_order("rnd_scan", base, 1);
                check_meas("rnd_scan");
            end
        end

        // eos collapse: three extra eos during one scan -> exactly two scans
        lat = 3;
        base = log_addr.size(); sd0 = done_cnt;
        pulse_eos();
        wait_log(base + 2, 100);
        pulse_eos();
        wait_log(base + 4, 100);
        pulse_eos();
        wait_log(base + 6, 100);
        pulse_eos();
        wait_done(sd0 + 2, 300);
        repeat (60) step();
        check("collapse_txn_count", 32'(log_addr.size()), 32'(base + 12));
        check_scan_order("collapse", base, 2);
        check("collapse_done_count", 32'(done_cnt), 32'(sd0 + 2));
        check("collapse_den_low", 32'(den), 0);
        check_meas("collapse");
        check("collapse_timeout_err", 32'(timeout_err), 0);

        // Timeout on VCCAUX read
        withhold = 8'h02;
        for (int a = 0; a < 6; a++) slave_regs[scan_list[a]] = slave_regs[scan_list[a]] ^ 16'h0F0F;
        for (int a = 0; a < 6; a++) model_regs[scan_list[a]] = model_regs[scan_list[a]] ^ 16'h0F0F;
        base = log_addr.size(); sd0 = done_cnt;
        pulse_eos();
        wait_done(sd0 + 1, 500);
        for (int i = 0; i < 6; i++)
            if (i != 2) exp_meas[i] = model_regs[scan_list[i]];
        check_scan_order("timeout", base, 1);
        if (log_addr.size() >= base + 4) begin
            t0 = log_cyc[base + 2];
            check("timeout_finish_cycle", 32'(to_cyc - t0), 32'd64);
            check("timeout_next_issue", 32'(log_cyc[base + 3] - t0), 32'd66);
        end
        check("timeout_err_set", 32'(timeout_err), 1);
        check_meas("timeout");
        withhold = 8'hFF;

        // Reset while in WAIT_RDY
        base = log_addr.size();
        pulse_eos();
        wait_log(base + 1, 100);
        step();
        RESET = 1'b1;
        #1;
        check("mrst_den", 32'(den), 0);
        check("mrst_dwe", 32'(dwe), 0);
        check("mrst_daddr", 32'(daddr), 0);
        check("mrst_di", 32'(di), 0);
        check("mrst_host_ack", 32'(host_ack), 0);
        check("mrst_host_do", 32'(host_do), 0);
        check("mrst_scan_done", 32'(scan_done), 0);
        check("mrst_timeout_err", 32'(timeout_err), 0);
        for (int i = 0; i < 6; i++) exp_meas[i] = '0;
        check_meas("mrst");
        repeat (2) step();
        RESET = 1'b0;
        den0 = den_cnt;
        repeat (100) step();
        check("mrst_no_den", 32'(den_cnt), 32'(den0));
        check("mrst_timeout_err_after", 32'(timeout_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
